// File: rtl/pipe_ctrl_pkg.sv
// Shared pause codes, zero word and FSM state encoding for the pipeline control unit.
package pipe_ctrl_pkg;

  localparam logic [2:0]  PAUSE_NONE = 3'd0;
  localparam logic [2:0]  PAUSE_PC   = 3'd1;
  localparam logic [2:0]  PAUSE_IF   = 3'd2;
  localparam logic [2:0]  PAUSE_ID   = 3'd3;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Bus-wait watchdog: counts consecutive bus_wait_i cycles and pulses bus_err_o once at the timeout.
module pipe_ctrl_wdog #(
  parameter int BUS_TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bus_wait_i,
  output logic bus_err_o
);

  localparam logic [15:0] TO_MAX  = 16'(BUS_TIMEOUT);
  localparam logic [15:0] TO_LAST = 16'(BUS_TIMEOUT - 1);

  logic [15:0] to_cnt_q, to_cnt_d;

  // Saturating at TO_MAX keeps the pulse comparison false until the wait ends.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (!bus_wait_i)
      to_cnt_d = 16'd0;
    else if (to_cnt_q != TO_MAX)
      to_cnt_d = to_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt_q <= 16'd0;
    else        to_cnt_q <= to_cnt_d;
  end

  assign bus_err_o = bus_wait_i & (to_cnt_q == TO_LAST);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges jump, stall, halt and bus-wait into one pause code plus PC redirect.
// Optional stall-cycle performance counter enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYC   = 2,
  parameter int BUS_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_req_i,
  input  logic [31:0] jump_addr_i,
  input  logic        div_busy_i,
  input  logic        bus_wait_i,
  input  logic        halt_req_i,
  output logic [2:0]  pause_flag_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        halted_o,
  output logic        bus_err_o,
  output logic [31:0] stall_cnt_o
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYC - 1);

  state_e      state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic [2:0]  pause_flag;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        stall;

  assign stall = div_busy_i | bus_wait_i;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pause_flag  = PAUSE_NONE;
    jump_flag   = 1'b0;
    jump_addr   = ZERO_WORD;
    case (state_q)
      ST_RUN: begin
        if (jump_req_i) begin
          jump_flag  = 1'b1;
          jump_addr  = jump_addr_i;
          pause_flag = PAUSE_ID;
          // The jump cycle itself is the first squash cycle.
          if (FLUSH_CYC > 1) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_INIT;
          end
        end else if (stall) begin
          pause_flag = PAUSE_ID;
        end else if (halt_req_i) begin
          state_d = ST_HALT;
        end
      end
      ST_FLUSH: begin
        pause_flag = PAUSE_ID;
        if (flush_cnt_q <= 4'd1) begin
          state_d     = ST_RUN;
          flush_cnt_d = 4'd0;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      ST_HALT: begin
        pause_flag = PAUSE_ID;
        if (!halt_req_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    // Combinational paths must not leak input activity while reset is held.
    if (!rst_n) begin
      pause_flag = PAUSE_NONE;
      jump_flag  = 1'b0;
      jump_addr  = ZERO_WORD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pause_flag_o = pause_flag;
  assign jump_flag_o  = jump_flag;
  assign jump_addr_o  = jump_addr;
  assign halted_o     = (state_q == ST_HALT);

  pipe_ctrl_wdog #(
    .BUS_TIMEOUT(BUS_TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_wait_i(bus_wait_i),
    .bus_err_o (bus_err_o)
  );

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((pause_flag != PAUSE_NONE) && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= 32'd0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = ZERO_WORD;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (FLUSH_CYC=2, BUS_TIMEOUT=256); inputs change 1ns after posedge.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic        jump_req_i;
  logic [31:0] jump_addr_i;
  logic        div_busy_i;
  logic        bus_wait_i;
  logic        halt_req_i;
  logic [2:0]  pause_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        halted_o;
  logic        bus_err_o;
  logic [31:0] stall_cnt_o;

  int total = 0;
  int bad   = 0;

  pipe_ctrl #(
    .FLUSH_CYC  (2),
    .BUS_TIMEOUT(256)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .jump_req_i  (jump_req_i),
    .jump_addr_i (jump_addr_i),
    .div_busy_i  (div_busy_i),
    .bus_wait_i  (bus_wait_i),
    .halt_req_i  (halt_req_i),
    .pause_flag_o(pause_flag_o),
    .jump_flag_o (jump_flag_o),
    .jump_addr_o (jump_addr_o),
    .halted_o    (halted_o),
    .bus_err_o   (bus_err_o),
    .stall_cnt_o (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge; checks then follow a further 1ns settle.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  int pulses;
  int pulse_at;
  logic [31:0] exp_stall;

  initial begin
    // Reset held with every input high
    rst_n = 1'b0; jump_req_i = 1'b1; jump_addr_i = 32'hFFFF_FFFF;
    div_busy_i = 1'b1; bus_wait_i = 1'b1; halt_req_i = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_pause",  {29'd0, pause_flag_o}, 32'd0);
    chk("rst_jflag",  {31'd0, jump_flag_o}, 32'd0);
    chk("rst_jaddr",  jump_addr_o, 32'd0);
    chk("rst_halted", {31'd0, halted_o}, 32'd0);
    chk("rst_buserr", {31'd0, bus_err_o}, 32'd0);
    chk("rst_stall",  stall_cnt_o, 32'd0);

    jump_req_i = 1'b0; jump_addr_i = 32'h0; div_busy_i = 1'b0;
    bus_wait_i = 1'b0; halt_req_i = 1'b0;
    next(); rst_n = 1'b1;
    next(); #1;
    chk("idle_pause",  {29'd0, pause_flag_o}, 32'd0);
    chk("idle_halted", {31'd0, halted_o}, 32'd0);

    // Jump: pause for the jump cycle plus one flush cycle
    next(); jump_req_i = 1'b1; jump_addr_i = 32'h0000_0100; #1;
    chk("jmp_flag",  {31'd0, jump_flag_o}, 32'd1);
    chk("jmp_addr",  jump_addr_o, 32'h0000_0100);
    chk("jmp_pause", {29'd0, pause_flag_o}, 32'd3);
    next(); jump_req_i = 1'b0; jump_addr_i = 32'h0; #1;
    chk("flush_pause", {29'd0, pause_flag_o}, 32'd3);
    chk("flush_jflag", {31'd0, jump_flag_o}, 32'd0);
    chk("flush_jaddr", jump_addr_o, 32'd0);
    next(); #1;
    chk("post_flush_pause", {29'd0, pause_flag_o}, 32'd0);

    // Divider stall for 5 cycles
    for (int i = 0; i < 5; i++) begin
      next(); div_busy_i = 1'b1; #1;
      chk("div_pause", {29'd0, pause_flag_o}, 32'd3);
    end
    next(); div_busy_i = 1'b0; #1;
    chk("div_done_pause", {29'd0, pause_flag_o}, 32'd0);
`ifdef PIPE_CTRL_PERF_EN
    exp_stall = 32'd7;
`else
    exp_stall = 32'd0;
`endif
    chk("stall_cnt", stall_cnt_o, exp_stall);

    // Jump and stall together: jump wins; a jump during flush is ignored
    next(); jump_req_i = 1'b1; div_busy_i = 1'b1; jump_addr_i = 32'h0000_0200; #1;
    chk("jmpdiv_flag",  {31'd0, jump_flag_o}, 32'd1);
    chk("jmpdiv_addr",  jump_addr_o, 32'h0000_0200);
    chk("jmpdiv_pause", {29'd0, pause_flag_o}, 32'd3);
    next(); div_busy_i = 1'b0; jump_addr_i = 32'h0000_0300; #1;
    chk("flush_jmp_ignored", {31'd0, jump_flag_o}, 32'd0);
    chk("flush2_pause", {29'd0, pause_flag_o}, 32'd3);
    next(); jump_req_i = 1'b0; jump_addr_i = 32'h0; #1;
    chk("run_again_pause", {29'd0, pause_flag_o}, 32'd0);
    chk("run_again_jflag", {31'd0, jump_flag_o}, 32'd0);

    // Halt for 10 cycles
    next(); halt_req_i = 1'b1; #1;
    chk("halt_entry_halted", {31'd0, halted_o}, 32'd0);
    for (int i = 1; i < 10; i++) begin
      next(); #1;
      chk("halt_halted", {31'd0, halted_o}, 32'd1);
      chk("halt_pause", {29'd0, pause_flag_o}, 32'd3);
    end
    next(); halt_req_i = 1'b0; #1;
    chk("halt_drop_halted", {31'd0, halted_o}, 32'd1);
    chk("halt_drop_pause", {29'd0, pause_flag_o}, 32'd3);
    next(); #1;
    chk("unhalt_halted", {31'd0, halted_o}, 32'd0);
    chk("unhalt_pause", {29'd0, pause_flag_o}, 32'd0);

    // Stall outranks halt entry
    next(); halt_req_i = 1'b1; div_busy_i = 1'b1;
    next(); #1;
    chk("halt_blocked", {31'd0, halted_o}, 32'd0);
    div_busy_i = 1'b0;
    next(); #1;
    chk("halt_after_stall", {31'd0, halted_o}, 32'd1);

    // Async reset mid-halt
    rst_n = 1'b0; #1;
    chk("rst_halt_halted", {31'd0, halted_o}, 32'd0);
    chk("rst_halt_pause", {29'd0, pause_flag_o}, 32'd0);
    chk("rst_halt_stall", stall_cnt_o, 32'd0);
    halt_req_i = 1'b0;
    next(); rst_n = 1'b1;

    // Async reset mid-flush
    next(); jump_req_i = 1'b1; jump_addr_i = 32'h0000_0400;
    next(); jump_req_i = 1'b0; jump_addr_i = 32'h0; #1;
    chk("pre_rst_flush_pause", {29'd0, pause_flag_o}, 32'd3);
    rst_n = 1'b0; #1;
    chk("rst_flush_pause", {29'd0, pause_flag_o}, 32'd0);
    next(); rst_n = 1'b1; #1;
    chk("post_rst_pause", {29'd0, pause_flag_o}, 32'd0);

    // Bus wait 300 cycles: one pulse on wait cycle 256
    pulses = 0; pulse_at = 0;
    for (int i = 1; i <= 300; i++) begin
      next(); bus_wait_i = 1'b1; #1;
      if (i == 1) chk("bus_pause", {29'd0, pause_flag_o}, 32'd3);
      if (bus_err_o) begin
        pulses++;
        pulse_at = i;
      end
    end
    chk("bus_pulses", pulses, 32'd1);
    chk("bus_pulse_at", pulse_at, 32'd256);

    // Drop one cycle, raise again: count restarts
    next(); bus_wait_i = 1'b0; #1;
    chk("bus_drop_err", {31'd0, bus_err_o}, 32'd0);
    chk("bus_drop_pause", {29'd0, pause_flag_o}, 32'd0);
    pulses = 0; pulse_at = 0;
    for (int i = 1; i <= 260; i++) begin
      next(); bus_wait_i = 1'b1; #1;
      if (bus_err_o) begin
        pulses++;
        pulse_at = i;
      end
    end
    chk("bus2_pulses", pulses, 32'd1);
    chk("bus2_pulse_at", pulse_at, 32'd256);
    next(); bus_wait_i = 1'b0; #1;
    chk("bus2_drop_err", {31'd0, bus_err_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
